attack_ctrl: RTL and testbench

ATTACK_CTRL -- requirements
Module: attack_ctrl

---
 rtl/attack_ctrl.sv | 140 ++++++++++++++
 tb/tb_attack_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/attack_ctrl.sv
// Attack controller: turns a fire-button press into a timed hitbox, followed by a lockout.
// Frame ticks pace both phases. The hitbox anchor is captured once per shot.
module attack_ctrl #(
    parameter int ACTIVE_FRAMES   = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int PLAYER_W        = 26,
    parameter int PLAYER_H        = 26,
    parameter int X_OFS           = 5,
    parameter int Y_OFS           = 5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       Fire_Key,
    input  logic [8:0] Player_X,
    input  logic [8:0] Player_Y,
    input  logic [1:0] Player_Direction,
    output logic [8:0] Attack_X,
    output logic [8:0] Attack_Y,
    output logic       Attack_On,
    output logic       Busy,
    output logic [7:0] Shot_Count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        COOLDOWN = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       frameClkDly_q;
    logic       tick_q;
    logic       fireKeyDly_q;
    logic       firePend_q, firePend_d;
    logic [7:0] frameCnt_q, frameCnt_d;
    logic [7:0] shotCnt_q, shotCnt_d;
    logic [8:0] attackX_q, attackX_d;
    logic [8:0] attackY_q, attackY_d;
    logic       fireEdge;
    logic [9:0] sumXOfs, sumXW, sumYOfs, sumYH;

    function automatic logic [8:0] sat9(input logic [9:0] v);
        return v[9] ? 9'd511 : v[8:0];
    endfunction

    assign fireEdge = Fire_Key & ~fireKeyDly_q;
    assign sumXOfs  = {1'b0, Player_X} + 10'(X_OFS);
    assign sumXW    = {1'b0, Player_X} + 10'(PLAYER_W);
    assign sumYOfs  = {1'b0, Player_Y} + 10'(Y_OFS);
    assign sumYH    = {1'b0, Player_Y} + 10'(PLAYER_H);

    // Delay registers reset high so a level already high at release is not seen as an edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frameClkDly_q <= 1'b1;
            fireKeyDly_q  <= 1'b1;
            tick_q        <= 1'b0;
        end else begin
            frameClkDly_q <= frame_clk;
            fireKeyDly_q  <= Fire_Key;
            tick_q        <= frame_clk & ~frameClkDly_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            firePend_q <= 1'b0;
            frameCnt_q <= 8'd0;
            shotCnt_q  <= 8'd0;
            attackX_q  <= 9'd0;
            attackY_q  <= 9'd0;
        end else begin
            state_q    <= state_d;
            firePend_q <= firePend_d;
            frameCnt_q <= frameCnt_d;
            shotCnt_q  <= shotCnt_d;
            attackX_q  <= attackX_d;
            attackY_q  <= attackY_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        firePend_d = firePend_q;
        frameCnt_d = frameCnt_q;
        shotCnt_d  = shotCnt_q;
        attackX_d  = attackX_q;
        attackY_d  = attackY_q;
        unique case (state_q)
            IDLE: begin
                if (tick_q && (firePend_q || fireEdge)) begin
                    state_d    = ACTIVE;
                    firePend_d = 1'b0;
                    frameCnt_d = 8'(ACTIVE_FRAMES);
                    shotCnt_d  = shotCnt_q + 8'd1;
                    unique case (Player_Direction)
                        2'd0: begin attackX_d = sat9(sumXOfs);   attackY_d = sat9(sumYH);   end
                        2'd1: begin attackX_d = Player_X;        attackY_d = sat9(sumYOfs); end
                        2'd2: begin attackX_d = sat9(sumXOfs);   attackY_d = Player_Y;      end
                        default: begin attackX_d = sat9(sumXW);  attackY_d = sat9(sumYOfs); end
                    endcase
                end else if (fireEdge) begin
                    firePend_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (tick_q) begin
                    if (frameCnt_q == 8'd1) begin
                        state_d    = COOLDOWN;
                        frameCnt_d = 8'(COOLDOWN_FRAMES);
                    end else begin
                        frameCnt_d = frameCnt_q - 8'd1;
                    end
                end
            end
            COOLDOWN: begin
                if (tick_q) begin
                    frameCnt_d = frameCnt_q - 8'd1;
                    if (frameCnt_q == 8'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        Attack_On  = (state_q == ACTIVE);
        Busy       = (state_q != IDLE);
        Attack_X   = attackX_q;
        Attack_Y   = attackY_q;
        Shot_Count = shotCnt_q;
    end

endmodule

// File: tb/tb_attack_ctrl.sv
// Directed bench for attack_ctrl: reset, single shot timing, directions, saturation,
// lockout, simultaneous fire/tick, counter wrap and mid-shot reset.
module tb_attack_ctrl;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic       Fire_Key;
    logic [8:0] Player_X;
    logic [8:0] Player_Y;
    logic [1:0] Player_Direction;
    logic [8:0] Attack_X;
    logic [8:0] Attack_Y;
    logic       Attack_On;
    logic       Busy;
    logic [7:0] Shot_Count;

    int vectors    = 0;
    int miscompares = 0;

    attack_ctrl dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .frame_clk        (frame_clk),
        .Fire_Key         (Fire_Key),
        .Player_X         (Player_X),
        .Player_Y         (Player_Y),
        .Player_Direction (Player_Direction),
        .Attack_X         (Attack_X),
        .Attack_Y         (Attack_Y),
        .Attack_On        (Attack_On),
        .Busy             (Busy),
        .Shot_Count       (Shot_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic applyStimulus(input logic fc, input logic fk);
        frame_clk = fc;
        Fire_Key  = fk;
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame tick; after return the FSM has already acted on it.
    task automatic doTick(input logic fk);
        applyStimulus(1'b1, fk);
        applyStimulus(1'b0, fk);
    endtask

    task automatic pressFire();
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic finishShot();
        repeat (12) doTick(1'b0);
    endtask

    initial begin
        int expX[3];
        int expY[3];
        expX = '{205, 200, 205};
        expY = '{146, 125, 120};

        Reset = 1'b1;
        Player_X = 9'd0;
        Player_Y = 9'd0;
        Player_Direction = 2'd0;
        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("reset_on", 32'(Attack_On), 32'd0);
        checkOutput("reset_busy", 32'(Busy), 32'd0);
        checkOutput("reset_shots", 32'(Shot_Count), 32'd0);
        checkOutput("reset_x", 32'(Attack_X), 32'd0);
        checkOutput("reset_y", 32'(Attack_Y), 32'd0);
        Reset = 1'b0;
        applyStimulus(1'b0, 1'b0);

        // Single shot facing right
        Player_X = 9'd100;
        Player_Y = 9'd50;
        Player_Direction = 2'd3;
        pressFire();
        checkOutput("pend_busy", 32'(Busy), 32'd0);
        checkOutput("pend_on", 32'(Attack_On), 32'd0);
        doTick(1'b0);
        checkOutput("shot1_on", 32'(Attack_On), 32'd1);
        checkOutput("shot1_busy", 32'(Busy), 32'd1);
        checkOutput("shot1_x", 32'(Attack_X), 32'd126);
        checkOutput("shot1_y", 32'(Attack_Y), 32'd55);
        checkOutput("shot1_cnt", 32'(Shot_Count), 32'd1);
        Player_X = 9'd10;
        Player_Y = 9'd10;
        doTick(1'b0);
        pressFire();
        doTick(1'b0);
        doTick(1'b0);
        checkOutput("active_t3_on", 32'(Attack_On), 32'd1);
        checkOutput("active_hold_x", 32'(Attack_X), 32'd126);
        doTick(1'b0);
        checkOutput("cool_on", 32'(Attack_On), 32'd0);
        checkOutput("cool_busy", 32'(Busy), 32'd1);
        doTick(1'b0);
        doTick(1'b0);
        applyStimulus(1'b0, 1'b1);
        repeat (5) doTick(1'b1);
        checkOutput("cool_t11_busy", 32'(Busy), 32'd1);
        doTick(1'b1);
        checkOutput("idle_busy", 32'(Busy), 32'd0);
        checkOutput("lockout_cnt", 32'(Shot_Count), 32'd1);
        doTick(1'b1);
        doTick(1'b1);
        checkOutput("held_on", 32'(Attack_On), 32'd0);
        checkOutput("held_cnt", 32'(Shot_Count), 32'd1);
        checkOutput("idle_hold_x", 32'(Attack_X), 32'd126);
        checkOutput("idle_hold_y", 32'(Attack_Y), 32'd55);
        applyStimulus(1'b0, 1'b0);

        // Remaining directions
        Player_X = 9'd200;
        Player_Y = 9'd120;
        for (int d = 0; d < 3; d++) begin
            Player_Direction = 2'(d);
            pressFire();
            doTick(1'b0);
            checkOutput($sformatf("dir%0d_on", d), 32'(Attack_On), 32'd1);
            checkOutput($sformatf("dir%0d_x", d), 32'(Attack_X), 32'(expX[d]));
            checkOutput($sformatf("dir%0d_y", d), 32'(Attack_Y), 32'(expY[d]));
            checkOutput($sformatf("dir%0d_cnt", d), 32'(Shot_Count), 32'(d + 2));
            finishShot();
        end
        checkOutput("dirs_idle", 32'(Busy), 32'd0);

        // Saturation near the bottom-right corner
        Player_X = 9'd500;
        Player_Y = 9'd500;
        Player_Direction = 2'd0;
        pressFire();
        doTick(1'b0);
        checkOutput("sat_down_x", 32'(Attack_X), 32'd505);
        checkOutput("sat_down_y", 32'(Attack_Y), 32'd511);
        finishShot();
        Player_Direction = 2'd3;
        pressFire();
        doTick(1'b0);
        checkOutput("sat_right_x", 32'(Attack_X), 32'd511);
        checkOutput("sat_right_y", 32'(Attack_Y), 32'd505);
        checkOutput("sat_cnt", 32'(Shot_Count), 32'd6);
        finishShot();

        // Fire edge lands on the same clock as the tick
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("simul_on", 32'(Attack_On), 32'd1);
        checkOutput("simul_cnt", 32'(Shot_Count), 32'd7);
        applyStimulus(1'b0, 1'b0);
        finishShot();

        // Reset during the second active tick
        pressFire();
        doTick(1'b0);
        checkOutput("pre_rst_cnt", 32'(Shot_Count), 32'd8);
        doTick(1'b0);
        doTick(1'b0);
        Reset = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("midrst_on", 32'(Attack_On), 32'd0);
        checkOutput("midrst_busy", 32'(Busy), 32'd0);
        checkOutput("midrst_cnt", 32'(Shot_Count), 32'd0);
        checkOutput("midrst_x", 32'(Attack_X), 32'd0);
        checkOutput("midrst_y", 32'(Attack_Y), 32'd0);
        Reset = 1'b0;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("postrst_on", 32'(Attack_On), 32'd1);
        checkOutput("postrst_cnt", 32'(Shot_Count), 32'd1);
        checkOutput("postrst_x", 32'(Attack_X), 32'd511);
        applyStimulus(1'b0, 1'b0);
        finishShot();

        // Shot counter wrap
        for (int i = 0; i < 254; i++) begin
            applyStimulus(1'b1, 1'b0);
            applyStimulus(1'b0, 1'b1);
            applyStimulus(1'b0, 1'b0);
            finishShot();
        end
        checkOutput("wrap_255", 32'(Shot_Count), 32'd255);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("wrap_0", 32'(Shot_Count), 32'd0);
        checkOutput("wrap_on", 32'(Attack_On), 32'd1);
        applyStimulus(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
